// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES/3DES round-key generator.
// One shared C/D register, rotator and PC-2 stage stream subkeys.
module des_key_schedule #(
  parameter int NUM_KEYS     = 1,
  parameter bit PARITY_CHECK = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [64*NUM_KEYS-1:0] key_in,
  input  logic                   mode,
  input  logic                   key_valid,
  output logic                   key_ready,
  output logic [47:0]            subkey,
  output logic [3:0]             subkey_round,
  output logic [1:0]             subkey_key,
  output logic                   subkey_last,
  output logic                   subkey_valid,
  input  logic                   subkey_ready,
  output logic [NUM_KEYS-1:0]    parity_err,
  output logic                   busy
);

  localparam int KW = 64*NUM_KEYS;
  localparam logic [1:0] LASTP = 2'(NUM_KEYS-1);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    58, 50, 42, 34, 26, 18, 10,  2,
    59, 51, 43, 35, 27, 19, 11,  3,
    60, 52, 44, 36, 63, 55, 47, 39,
    31, 23, 15,  7, 62, 54, 46, 38,
    30, 22, 14,  6, 61, 53, 45, 37,
    29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28,
    15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56,
    34, 53, 46, 42, 50, 36, 29, 32
  };

  generate
    if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_keys
      $error("des_key_schedule: NUM_KEYS must be 1 or 3");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   keys_q, keys_d;
  logic            mode_q, mode_d;
  logic [NUM_KEYS-1:0] perr_q, perr_d;
  logic [1:0]      pass_q, pass_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [27:0]     c_q, c_d;
  logic [27:0]     d_q, d_d;
  logic [47:0]     sk_q, sk_d;

  logic            ld, adv;
  logic            m_use, dir;
  logic [1:0]      p_use;
  logic [KW-1:0]   src;
  logic [3:0]      r_use;
  logic [55:0]     cd0;
  logic [1:0]      sh;
  logic [27:0]     c_rot, d_rot;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[i] = k[PC1[i]-1];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[i] = cd[PC2[i]-1];
    return o;
  endfunction

  // index 0 is DES bit 1, so a DES left rotate is a shift toward bit 0
  function automatic logic [27:0] rot(
    input logic [27:0] x,
    input logic [1:0]  n,
    input logic        dec
  );
    logic [27:0] o;
    o = x;
    if (dec) begin
      case (n)
        2'd1:    o = {x[26:0], x[27]};
        2'd2:    o = {x[25:0], x[27:26]};
        default: o = x;
      endcase
    end else begin
      case (n)
        2'd1:    o = {x[0], x[27:1]};
        2'd2:    o = {x[1:0], x[27:2]};
        default: o = x;
      endcase
    end
    return o;
  endfunction

  function automatic logic [1:0] shamt(
    input logic [3:0] r,
    input logic       dec
  );
    logic one;
    one = (r == 4'd0) || (r == 4'd1) ||
          (r == 4'd8) || (r == 4'd15);
    if (dec && r == 4'd0) return 2'd0;
    return one ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:0] pkey(
    input logic [1:0] p,
    input logic       m
  );
    if (NUM_KEYS == 1) return 2'd0;
    return m ? 2'd2 - p : p;
  endfunction

  // EDE: the middle pass runs opposite to the outer ones
  function automatic logic pdir(
    input logic [1:0] p,
    input logic       m
  );
    if (NUM_KEYS == 1) return m;
    return m ^ (p == 2'd1);
  endfunction

  function automatic logic [63:0] ksel(
    input logic [KW-1:0] ks,
    input logic [1:0]    idx
  );
    logic [63:0] o;
    o = ks[63:0];
    for (int j = 1; j < NUM_KEYS; j++)
      if (idx == 2'(j)) o = ks[64*j +: 64];
    return o;
  endfunction

  function automatic logic [NUM_KEYS-1:0] par(
    input logic [KW-1:0] ks
  );
    logic [NUM_KEYS-1:0] o;
    o = '0;
    for (int j = 0; j < NUM_KEYS; j++)
      for (int b = 0; b < 8; b++)
        o[j] = o[j] | ~(^ks[64*j+8*b +: 8]);
    return PARITY_CHECK ? o : '0;
  endfunction

  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    mode_d  = mode_q;
    perr_d  = perr_q;
    pass_d  = pass_q;
    rnd_d   = rnd_q;
    c_d     = c_q;
    d_d     = d_q;
    sk_d    = sk_q;
    ld      = 1'b0;
    adv     = 1'b0;
    m_use   = mode_q;
    p_use   = pass_q;
    src     = keys_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = RUN;
          keys_d  = key_in;
          mode_d  = mode;
          perr_d  = par(key_in);
          ld      = 1'b1;
          m_use   = mode;
          p_use   = 2'd0;
          src     = key_in;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (rnd_q != 4'd15) begin
            adv = 1'b1;
          end else if (pass_q == LASTP) begin
            state_d = IDLE;
          end else begin
            ld    = 1'b1;
            p_use = pass_q + 2'd1;
          end
        end
      end
    endcase
    dir   = pdir(p_use, m_use);
    r_use = ld ? 4'd0 : rnd_q + 4'd1;
    cd0   = ld ? pc1(ksel(src, pkey(p_use, m_use)))
               : {d_q, c_q};
    sh    = shamt(r_use, dir);
    c_rot = rot(cd0[27:0], sh, dir);
    d_rot = rot(cd0[55:28], sh, dir);
    if (ld || adv) begin
      c_d    = c_rot;
      d_d    = d_rot;
      sk_d   = pc2({d_rot, c_rot});
      rnd_d  = r_use;
      pass_d = p_use;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      keys_q  <= '0;
      mode_q  <= 1'b0;
      perr_q  <= '0;
      pass_q  <= '0;
      rnd_q   <= '0;
      c_q     <= '0;
      d_q     <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      mode_q  <= mode_d;
      perr_q  <= perr_d;
      pass_q  <= pass_d;
      rnd_q   <= rnd_d;
      c_q     <= c_d;
      d_q     <= d_d;
      sk_q    <= sk_d;
    end
  end

  assign key_ready    = (state_q == IDLE);
  assign busy         = ~key_ready;
  assign subkey_valid = (state_q == RUN);
  assign subkey       = sk_q;
  assign subkey_round = rnd_q;
  assign subkey_key   = pkey(pass_q, mode_q);
  assign subkey_last  = subkey_valid && (rnd_q == 4'd15) &&
                        (pass_q == LASTP);
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: DES and 3DES instances checked against a
// textbook key-schedule model (MSB = DES bit 1).
module tb_des_key_schedule;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    58, 50, 42, 34, 26, 18, 10,  2,
    59, 51, 43, 35, 27, 19, 11,  3,
    60, 52, 44, 36, 63, 55, 47, 39,
    31, 23, 15,  7, 62, 54, 46, 38,
    30, 22, 14,  6, 61, 53, 45, 37,
    29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28,
    15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56,
    34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  typedef struct packed {
    logic [47:0] k;
    logic [3:0]  r;
    logic [1:0]  kk;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [63:0]  key1;
  logic         mode1, kv1, rdy1, kr1, last1, sv1, busy1;
  logic [47:0]  sk1;
  logic [3:0]   rnd1;
  logic [1:0]   kk1;
  logic [0:0]   pe1;

  logic [191:0] key3;
  logic         mode3, kv3, rdy3, kr3, last3, sv3, busy3;
  logic [47:0]  sk3;
  logic [3:0]   rnd3;
  logic [1:0]   kk3;
  logic [2:0]   pe3;

  int checks = 0;
  int failures = 0;
  int tx1 = 0;
  int tx3 = 0;
  exp_t q1[$];
  exp_t q3[$];

  des_key_schedule #(.NUM_KEYS(1), .PARITY_CHECK(1)) u1 (
    .clk(clk), .rst(rst), .key_in(key1), .mode(mode1),
    .key_valid(kv1), .key_ready(kr1), .subkey(sk1),
    .subkey_round(rnd1), .subkey_key(kk1),
    .subkey_last(last1), .subkey_valid(sv1),
    .subkey_ready(rdy1), .parity_err(pe1), .busy(busy1)
  );

  des_key_schedule #(.NUM_KEYS(3), .PARITY_CHECK(1)) u3 (
    .clk(clk), .rst(rst), .key_in(key3), .mode(mode3),
    .key_valid(kv3), .key_ready(kr3), .subkey(sk3),
    .subkey_round(rnd3), .subkey_key(kk3),
    .subkey_last(last3), .subkey_valid(sv3),
    .subkey_ready(rdy3), .parity_err(pe3), .busy(busy3)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[i] = x[63-i];
    return o;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[i] = x[47-i];
    return o;
  endfunction

  // textbook schedule: K1..K16 at [48*(n-1) +: 48], MSB first
  function automatic logic [767:0] sched(input logic [63:0] ks);
    logic [767:0] o;
    logic [55:0]  cd;
    logic [27:0]  c, d;
    o = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = ks[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) o[48*r + 47 - i] = cd[56-PC2[i]];
    end
    return o;
  endfunction

  function automatic logic [2:0] par_exp(input logic [191:0] kd,
                                         input int nk);
    logic [2:0] p;
    p = '0;
    for (int j = 0; j < nk; j++)
      for (int b = 0; b < 8; b++)
        if ($countones(kd[64*j+8*b +: 8]) % 2 == 0) p[j] = 1'b1;
    return p;
  endfunction

  function automatic logic [63:0] make_odd(input logic [63:0] k);
    logic [63:0] o;
    o = k;
    for (int b = 0; b < 8; b++)
      if ($countones(o[8*b +: 8]) % 2 == 0) o[8*b] = ~o[8*b];
    return o;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic build(input int nk, input logic [191:0] kd,
                       input logic m);
    int ko [3];
    bit dd [3];
    logic [767:0] s;
    exp_t e;
    if (nk == 1) begin
      ko = '{0, 0, 0}; dd = '{m, 0, 0};
    end else if (!m) begin
      ko = '{0, 1, 2}; dd = '{0, 1, 0};
    end else begin
      ko = '{2, 1, 0}; dd = '{1, 0, 1};
    end
    for (int p = 0; p < nk; p++) begin
      s = sched(rev64(kd[64*ko[p] +: 64]));
      for (int r = 0; r < 16; r++) begin
        e.k    = dd[p] ? s[48*(15-r) +: 48] : s[48*r +: 48];
        e.r    = 4'(r);
        e.kk   = 2'(ko[p]);
        e.last = (p == nk-1) && (r == 15);
        if (nk == 1) q1.push_back(e);
        else q3.push_back(e);
      end
    end
  endtask

  function automatic logic sv_of(input int nk);
    return nk == 1 ? sv1 : sv3;
  endfunction
  function automatic logic kr_of(input int nk);
    return nk == 1 ? kr1 : kr3;
  endfunction
  function automatic logic last_of(input int nk);
    return nk == 1 ? last1 : last3;
  endfunction
  function automatic logic [3:0] rnd_of(input int nk);
    return nk == 1 ? rnd1 : rnd3;
  endfunction
  function automatic logic [47:0] sk_of(input int nk);
    return nk == 1 ? sk1 : sk3;
  endfunction
  function automatic logic [2:0] pe_of(input int nk);
    return nk == 1 ? {2'b00, pe1} : pe3;
  endfunction
  function automatic int qn(input int nk);
    return nk == 1 ? q1.size() : q3.size();
  endfunction
  function automatic int tx_of(input int nk);
    return nk == 1 ? tx1 : tx3;
  endfunction

  task automatic drive(input int nk, input logic [191:0] kd,
                       input logic m, input logic kv, input logic r);
    if (nk == 1) begin
      key1 = kd[63:0]; mode1 = m; kv1 = kv; rdy1 = r;
    end else begin
      key3 = kd; mode3 = m; kv3 = kv; rdy3 = r;
    end
  endtask

  task automatic run(input int nk, input logic [191:0] kd,
                     input logic m, input bit rnd_rdy,
                     input bit stall5, input bit pulse, input bit lit,
                     input logic [47:0] lf, input logic [47:0] ll);
    logic [2:0]   pe_e;
    logic [47:0]  lastk;
    logic [191:0] kx;
    logic         r, kvv;
    int           st;
    bit           stalled;
    string        t;
    t = $sformatf("u%0d_m%0d", nk, m);
    st = 0;
    stalled = 0;
    lastk = '0;
    build(nk, kd, m);
    if (nk == 1) tx1 = 0;
    else tx3 = 0;
    pe_e = par_exp(kd, nk);
    chk({t, "_ready_idle"}, 64'(kr_of(nk)), 64'(1));
    drive(nk, kd, m, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(nk, kd, m, 1'b0, 1'b1);
    chk({t, "_latency"}, 64'(sv_of(nk)), 64'(1));
    chk({t, "_parity"}, 64'(pe_of(nk)), 64'(pe_e));
    if (lit) chk({t, "_first_lit"}, 64'(rev48(sk_of(nk))), 64'(lf));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (qn(nk) == 0) break;
      chk({t, "_valid_midstream"}, 64'(sv_of(nk)), 64'(1));
      if (sv_of(nk) && last_of(nk)) lastk = sk_of(nk);
      if (st > 0) begin
        r = 1'b0; st--;
      end else if (stall5 && !stalled && sv_of(nk) &&
                   rnd_of(nk) == 4'd5) begin
        r = 1'b0; st = 2; stalled = 1;
      end else begin
        r = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      kvv = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      kx  = pulse ? {rnd64(), rnd64(), rnd64()} : kd;
      drive(nk, kx, pulse ? 1'($urandom_range(0, 1)) : m, kvv, r);
      @(posedge clk); #1;
    end
    drive(nk, kd, m, 1'b0, 1'b1);
    chk({t, "_drained"}, 64'(qn(nk)), 64'(0));
    chk({t, "_transfers"}, 64'(tx_of(nk)), 64'(16*nk));
    chk({t, "_done_valid"}, 64'(sv_of(nk)), 64'(0));
    chk({t, "_done_ready"}, 64'(kr_of(nk)), 64'(1));
    chk({t, "_parity_hold"}, 64'(pe_of(nk)), 64'(pe_e));
    if (lit) chk({t, "_last_lit"}, 64'(rev48(lastk)), 64'(ll));
  endtask

  task automatic rst_test(input logic [63:0] kd);
    build(1, {128'b0, kd}, 1'b0);
    tx1 = 0;
    drive(1, {128'b0, kd}, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1, {128'b0, kd}, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sv1 && rnd1 == 4'd7) break;
      @(posedge clk); #1;
    end
    chk("rst_reach_round7", 64'(rnd1), 64'(7));
    chk("rst_parity_before", 64'(pe1), 64'(1));
    rst = 1'b1;
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid", 64'(sv1), 64'(0));
    chk("rst_ready", 64'(kr1), 64'(1));
    chk("rst_subkey", 64'(sk1), 64'(0));
    chk("rst_round", 64'(rnd1), 64'(0));
    chk("rst_key", 64'(kk1), 64'(0));
    chk("rst_last", 64'(last1), 64'(0));
    chk("rst_parity", 64'(pe1), 64'(0));
    chk("rst_busy", 64'(busy1), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_subkey", 64'(sv1), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("u1_busy", 64'(busy1), 64'(!kr1));
      chk("u3_busy", 64'(busy3), 64'(!kr3));
      if (sv1) begin
        chk("u1_queue_nonempty", 64'(q1.size() != 0), 64'(1));
        if (q1.size() != 0) begin
          chk("u1_subkey", 64'(rev48(sk1)), 64'(q1[0].k));
          chk("u1_round", 64'(rnd1), 64'(q1[0].r));
          chk("u1_keyidx", 64'(kk1), 64'(q1[0].kk));
          chk("u1_last", 64'(last1), 64'(q1[0].last));
          if (rdy1) begin
            void'(q1.pop_front());
            tx1++;
          end
        end
      end
      if (sv3) begin
        chk("u3_queue_nonempty", 64'(q3.size() != 0), 64'(1));
        if (q3.size() != 0) begin
          chk("u3_subkey", 64'(rev48(sk3)), 64'(q3[0].k));
          chk("u3_round", 64'(rnd3), 64'(q3[0].r));
          chk("u3_keyidx", 64'(kk3), 64'(q3[0].kk));
          chk("u3_last", 64'(last3), 64'(q3[0].last));
          if (rdy3) begin
            void'(q3.pop_front());
            tx3++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [767:0] s;
    logic [63:0]  kdes, kp;
    logic [191:0] k3;
    drive(1, '0, 1'b0, 1'b0, 1'b1);
    drive(3, '0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready1", 64'(kr1), 64'(1));
    chk("reset_valid1", 64'(sv1), 64'(0));
    chk("reset_subkey1", 64'(sk1), 64'(0));
    chk("reset_round1", 64'(rnd1), 64'(0));
    chk("reset_last1", 64'(last1), 64'(0));
    chk("reset_parity1", 64'(pe1), 64'(0));
    chk("reset_ready3", 64'(kr3), 64'(1));
    chk("reset_valid3", 64'(sv3), 64'(0));
    chk("reset_key3", 64'(kk3), 64'(0));
    chk("reset_parity3", 64'(pe3), 64'(0));

    s = sched(64'h133457799BBCDFF1);
    chk("model_k1", 64'(s[47:0]), 64'(48'h1B02EFFC7072));
    chk("model_k16", 64'(s[767:720]), 64'(48'hCB3D8B0E17F5));

    kdes = rev64(64'h133457799BBCDFF1);
    run(1, {128'b0, kdes}, 1'b0, 0, 0, 0, 1,
        48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
    run(1, {128'b0, kdes}, 1'b1, 0, 0, 0, 1,
        48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
    run(1, {128'b0, kdes}, 1'b0, 1, 1, 1, 0, '0, '0);

    kp = make_odd(rnd64());
    kp[16] = ~kp[16];
    run(1, {128'b0, kp}, 1'b1, 1, 0, 0, 0, '0, '0);
    chk("u1_parity_lit", 64'(pe1), 64'(1));

    for (int i = 0; i < 4; i++)
      run(1, {128'b0, rnd64()}, 1'($urandom_range(0, 1)),
          1, 0, 1, 0, '0, '0);

    k3 = {make_odd(rnd64()), make_odd(rnd64()), make_odd(rnd64())};
    run(3, k3, 1'b0, 0, 0, 0, 0, '0, '0);
    chk("u3_parity_clean", 64'(pe3), 64'(0));
    run(3, k3, 1'b1, 0, 0, 0, 0, '0, '0);
    k3[80] = ~k3[80];
    run(3, k3, 1'b0, 1, 1, 1, 0, '0, '0);
    chk("u3_parity_lit", 64'(pe3), 64'(3'b010));
    run(3, {rnd64(), rnd64(), rnd64()}, 1'b1, 1, 0, 1, 0, '0, '0);

    rst_test(kp);
    run(1, {128'b0, kdes}, 1'b0, 0, 0, 0, 1,
        48'h1B02EFFC7072, 48'hCB3D8B0E17F5);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES/3DES round-key generator for the encryption datapath. It accepts one 64-bit DES key, or three for 3DES, and applies PC-1 internally. It then streams 48-bit PC-2 subkeys one per handshake, in encrypt or decrypt order, to the round engine. This replaces combinational per-round PC-2 instances with a single shared C/D register, rotator and PC-2 stage.

Parameters:
NUM_KEYS, 1, number of DES keys per load; legal values 1 (DES) and 3 (3DES EDE); any other value is a elaboration error.
PARITY_CHECK, 1, 1 = compute per-byte odd-parity flags on load; 0 = parity_err tied to 0.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
key_in  in  64*NUM_KEYS  key j on key_in[64j+63:64j]; within a key, index 0 = DES bit 1 (same convention as the PC-2 tables)
mode  in  1  0 = encrypt order, 1 = decrypt order; sampled with key
key_valid  in  1  key_in/mode valid
key_ready  out  1  block can accept a key (IDLE)
subkey  out  48  current round key; index 0 = DES subkey bit 1
subkey_round  out  4  position 0..15 within the current pass
subkey_key  out  2  index of the key (0..NUM_KEYS-1) used by the current pass
subkey_last  out  1  final subkey of the final pass
subkey_valid  out  1  subkey fields valid
subkey_ready  in  1  consumer accepts subkey
parity_err  out  NUM_KEYS  bit j = 1 if any byte of key j has even parity; held until next load
busy  out  1  = ~key_ready

Behaviour:
- Reset: state IDLE; key_ready=1 (first cycle after rst deasserts); subkey_valid=0, subkey=0, subkey_round=0, subkey_key=0, subkey_last=0, parity_err=0, busy=0; all C/D and latched key registers cleared. Reset mid-stream aborts immediately; no further subkeys are emitted.
- States: IDLE, RUN.
- IDLE -> RUN on key_valid && key_ready. In the same edge:
  - latch all keys and mode;
  - latch parity_err (bit j = XOR-reduce of each byte of key j == 0, ORed over its 8 bytes);
  - load C/D with PC-1 of the first pass's key;
  - register the first subkey.
- key_valid is ignored outside IDLE.
- Latency: subkey_valid=1 the cycle after key acceptance. Throughput is one subkey per cycle while subkey_ready=1.
- Pass sequence, as (key, direction):
  - NUM_KEYS=1: mode0 = (0, enc); mode1 = (0, dec).
  - NUM_KEYS=3, mode0: (0, enc), (1, dec), (2, enc).
  - NUM_KEYS=3, mode1: (2, dec), (1, enc), (0, dec).
- C = PC1out[27:0], D = PC1out[55:28], with PC1out indexed as DES bits 1..56.
- One DES left rotate is newC[i] = C[(i+1) mod 28]; D likewise.
- enc pass, position r:
  - rotate left by SH[r], where SH = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1;
  - emit PC-2 of the rotated C/D; this is K(r+1).
- dec pass, position r:
  - rotate right by RS[r], where RS = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1;
  - emit PC-2; this is K(16-r).
  - Position 0 uses the unrotated PC-1 value, since total rotation is 28.
- Handshake rules:
  - Transfer occurs when subkey_valid && subkey_ready.
  - While subkey_valid && !subkey_ready, all subkey fields and C/D hold stable.
  - subkey_valid never drops mid-stream except on rst.
- Pass boundary: after the transfer at position 15, the next cycle presents position 0 of the next pass. C/D is reloaded from PC-1 of the next key, with no bubble.
- subkey_last = 1 only at position 15 of the last pass.
- On that transfer: RUN -> IDLE; subkey_valid=0 and key_ready=1 the next cycle. A new key cannot be accepted in the same cycle as the last transfer.
- Total transfers per load: 16*NUM_KEYS.

Test Plan:
- DES encrypt: NUM_KEYS=1, key 0x133457799BBCDFF1 (DES bit order), mode0, subkey_ready=1 -> first subkey 0x1B02EFFC7072 one cycle after accept; subkey_round 0..15 on consecutive cycles; 16th subkey 0xCB3D8B0E17F5 with subkey_last=1; parity_err=0; key_ready=1 the cycle after.
- DES decrypt: same key, mode1 -> first subkey 0xCB3D8B0E17F5, last subkey 0x1B02EFFC7072; sequence is the exact reverse of the encrypt run.
- Backpressure: deassert subkey_ready for 3 cycles at round 5, and randomly thereafter -> fields stable while stalled; no skipped or duplicated rounds; exactly 16 transfers.
- 3DES: NUM_KEYS=3, keys K0/K1/K2 distinct, mode0 -> 48 transfers; subkey_key 0,1,2; pass 1 equals K1's DES-decrypt sequence; no bubble at either pass boundary. With mode1 -> subkey_key order 2,1,0.
- Parity/protocol: flip bit 0 of key byte 2 -> parity_err=1 (bit of that key only) and subkeys still generated; key_valid pulses during RUN are ignored.
- Reset: assert rst at round 7 -> next cycle subkey_valid=0, key_ready=1, all outputs at reset values. A new key then yields a correct sequence from round 0.
